// File: rtl/bram_port_arbiter_pkg.sv
// ============================================================================
// Module  : bram_port_arbiter_pkg
// Purpose : Shared BRAM geometry constants and the width helper used by the
//           BRAM port arbiter and its round-robin sub-module.
// Contents: c_bram_addr_w, c_bram_data_w, c_bram_rd_lat, idx_width()
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_port_arbiter_pkg;

  // Geometry of the dual-port 1024x8 block RAM shared by all its users.
  localparam int c_bram_addr_w = 10;
  localparam int c_bram_data_w = 8;
  localparam int c_bram_rd_lat = 2;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Purpose : Round-robin arbiter. Searches from ptr+1 (wrapping) for the first
//           asserted request and issues a one-hot grant plus encoded index.
//           Owns the pointer, which moves to the winner on every grant.
// Ports   : clk, rst        clock / synchronous active-high reset
//           req            request vector
//           grant          one-hot grant (all zero while rst = 1)
//           grant_idx      encoded winner index
//           grant_any      a grant is issued this cycle
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  // Reset to the last index so that requester 0 is searched first.
  localparam logic [IDX_W-1:0] c_ptr_rst = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    w_cand    = '0;
    // No grants while in reset, so nothing is accepted on a reset edge.
    if (!rst) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
        if (!grant_any && req[w_cand]) begin
          grant_any     = 1'b1;
          grant_idx     = w_cand;
          grant[w_cand] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= c_ptr_rst;
    end else if (grant_any) begin
      r_ptr <= grant_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bram_port_arbiter.sv
// ============================================================================
// Module  : bram_port_arbiter
// Purpose : Shares one port of a 1024x8 block RAM among NUM_REQ requesters.
//           Round-robin, one access per cycle; read tags ride an RD_LAT-deep
//           shift register so each read response is steered back to its
//           issuing requester in issue order.
// Ports   : clk, rst          clock / synchronous active-high reset
//           req_valid/we     per-requester request and write flag
//           req_addr/wdata   packed per-requester address and write data
//           req_ready        one-hot grant (accept = valid & ready)
//           rsp_valid        one-hot read-data strobe
//           rsp_data         broadcast read data (BRAM output passthrough)
//           mem_addr/we/din  drive to the BRAM port
//           mem_dout         data from the BRAM port
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = c_bram_addr_w,
  parameter int DATA_W  = c_bram_data_w,
  parameter int RD_LAT  = c_bram_rd_lat
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_din,
  input  logic [DATA_W-1:0]         mem_dout
);

  localparam int c_idx_w = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0] w_grant;
  logic [c_idx_w-1:0] w_grant_idx;
  logic               w_grant_any;
  logic               w_rd_accept;

  logic               r_tag_vld [RD_LAT];
  logic [c_idx_w-1:0] r_tag_idx [RD_LAT];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_idx_w)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  assign req_ready = w_grant;

  // Grant is one-hot, so a plain priority-free select of the winner suffices;
  // with no grant every memory output falls back to zero.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        mem_addr = req_addr[i*ADDR_W +: ADDR_W];
        mem_din  = req_wdata[i*DATA_W +: DATA_W];
        mem_we   = req_we[i];
      end
    end
  end

  assign w_rd_accept = w_grant_any && !mem_we;

  // Read-tag pipeline: matches the BRAM's address-then-data register stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        r_tag_vld[s] <= 1'b0;
        r_tag_idx[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_rd_accept;
      r_tag_idx[0] <= w_grant_idx;
      for (int s = 1; s < RD_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = r_tag_vld[RD_LAT-1] &&
                     (r_tag_idx[RD_LAT-1] == c_idx_w'(i));
    end
  end

  assign rsp_data = mem_dout;

endmodule

`default_nettype wire
